byte_serial_multiplier: RTL and testbench

//   Sequential radix-256 shift-and-add multiplier. It consumes one multiplier byte per cycle.

---
 rtl/byte_serial_multiplier_pkg.sv | 17 +
 rtl/byte_serial_multiplier_pp.sv | 29 ++
 rtl/byte_serial_multiplier.sv | 122 ++++++++++++
 tb/tb_byte_serial_multiplier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/byte_serial_multiplier_pkg.sv
// Shared constants and FSM state type for the byte-serial multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul_pkg;

  localparam int WORD_W     = 64;
  localparam int DIGIT_W    = 8;
  localparam int NUM_STEPS  = WORD_W / DIGIT_W;
  localparam int STEP_CNT_W = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage : mul_pkg

// File: rtl/byte_serial_multiplier_pp.sv
// Combinational WIDTH x DIGIT partial product, truncated to WIDTH bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
//
// Ports:
//   mcand  in  WIDTH  multiplicand (already shifted into position)
//   digit  in  DIGIT  current multiplier digit
//   pp     out WIDTH  (mcand * digit) mod 2^WIDTH
module byte_partial_product
  import mul_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIGIT = DIGIT_W
) (
  input  logic [WIDTH-1:0] mcand,
  input  logic [DIGIT-1:0] digit,
  output logic [WIDTH-1:0] pp
);

  logic [WIDTH-1:0] digit_ext;

  // Zero-extending the digit keeps the multiply self-determined at WIDTH bits,
  // so the upper product bits are discarded by construction.
  always_comb begin
    digit_ext = WIDTH'(digit);
    pp        = mcand * digit_ext;
  end

endmodule : byte_partial_product

// File: rtl/byte_serial_multiplier.sv
// Radix-2^DIGIT shift-and-add multiplier: product = (a*b) mod 2^WIDTH, one digit of b per cycle.
// Latency: out_valid rises WIDTH/DIGIT edges after the accept edge (fewer with MUL_EARLY_TERM_EN).
// Backpressure: in_ready only in IDLE; result holds in DONE until out_ready, one op in flight.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in_valid/in_ready, a, b        operand handshake; a,b sampled on the accept edge only
//   out_valid/out_ready, product   result handshake; product reads 0 outside DONE
// Build option: define MUL_EARLY_TERM_EN to stop as soon as the remaining multiplier
// digits are all zero (b==0 skips BUSY entirely). Product value is unaffected.
module byte_serial_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DIGIT = DIGIT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pp;
  logic             last_step;

  byte_partial_product #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_pp (
    .mcand (mcand_q),
    .digit (mplier_q[DIGIT-1:0]),
    .pp    (pp)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    product   = '0;

`ifdef MUL_EARLY_TERM_EN
    // Nothing left to add once every remaining digit above the current one is zero.
    last_step = (cnt_q == LAST_CNT) || ((mplier_q >> DIGIT) == '0);
`else
    last_step = (cnt_q == LAST_CNT);
`endif

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d    = '0;
          mcand_d  = a;
          mplier_d = b;
          cnt_d    = '0;
`ifdef MUL_EARLY_TERM_EN
          state_d  = (b == '0) ? DONE : BUSY;
`else
          state_d  = BUSY;
`endif
        end
      end

      BUSY: begin
        acc_d    = acc_q + pp;
        mcand_d  = {mcand_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
        mplier_d = mplier_q >> DIGIT;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        product   = acc_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule : byte_serial_multiplier

// File: tb/tb_byte_serial_multiplier.sv
// Directed bench for byte_serial_multiplier with a cycle-level reference model.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and ignored in_valid while busy.
`ifdef MUL_EARLY_TERM_EN
`define TB_LAT(e) (e)
`else
`define TB_LAT(e) (8)
`endif

module tb_byte_serial_multiplier;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model: phase 0 idle, 1 computing, 2 result presented.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [63:0] m_prod  = '0;

  byte_serial_multiplier dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Number of BUSY edges the operation should take, derived from b's digit content.
  function automatic int lat_of(input logic [63:0] bv);
    int hi;
    hi = -1;
    for (int i = 0; i < 8; i++) begin
      if (bv[i*8 +: 8] != 8'h00) hi = i;
    end
`ifdef MUL_EARLY_TERM_EN
    return hi + 1;
`else
    return (hi > 99) ? 0 : 8;
`endif
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_prod  = a * b;
          m_left  = lat_of(b);
          m_phase = (m_left == 0) ? 2 : 1;
        end
        1: begin
          m_left = m_left - 1;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_in_ready", {63'd0, in_ready}, {63'd0, m_phase == 0});
      check("model_out_valid", {63'd0, out_valid}, {63'd0, m_phase == 2});
      check("model_product", product, (m_phase == 2) ? m_prod : 64'd0);
    end
  end

  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_b,
                        input logic [63:0] exp_p, input int exp_lat, input int hold);
    int edges;
    @(negedge clock);
    check("in_ready_before", {63'd0, in_ready}, 64'd1);
    a         = ta;
    b         = tb_b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    edges    = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    check("latency", 64'(edges), 64'(exp_lat));
    check("product", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = 64'h5;
      b        = 64'h5;
      @(posedge clock);
      @(negedge clock);
      check("hold_product", product, exp_p);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);
    check("out_valid_after", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    @(posedge clock);
    chk_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_product", product, 64'd0);

    run_op(64'd3, 64'd5, 64'd15, `TB_LAT(1), 0);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, `TB_LAT(1), 0);
    run_op(64'h0123_4567_89AB_CDEF, 64'h100, 64'h2345_6789_ABCD_EF00, `TB_LAT(2), 0);
    run_op(64'd7, 64'd9, 64'd63, `TB_LAT(1), 5);
    run_op(64'h1_0000_0001, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, `TB_LAT(4), 0);
    run_op(64'h1234, 64'h12, 64'h147A8, `TB_LAT(1), 0);
    run_op(64'hDEAD, 64'h0, 64'h0, `TB_LAT(0), 0);

    // Reset in the middle of a computation discards it.
    @(negedge clock);
    a        = 64'h55;
    b        = 64'hFF00_0000_0000_0001;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    check("busy_out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    check("midreset_product", product, 64'd0);

    run_op(64'd10, 64'd10, 64'd100, `TB_LAT(1), 0);

    repeat (3) @(posedge clock);
    chk_en = 1'b0;
    @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_byte_serial_multiplier
